tick_sequencer: RTL and testbench

TICK_SEQUENCER -- requirements
Module: tick_sequencer

---
 rtl/tick_pkg.sv | 21 ++
 rtl/tick_select.sv | 37 +++
 rtl/tick_sequencer.sv | 111 +++++++++++
 tb/tb_tick_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
// Shared types for the tick sequencer: tick-source encodings, FSM states
// and the default step-counter width.
package tick_pkg;

    localparam int STEP_W_DEF = 4;

    typedef enum logic [1:0] {
        RATE_1HZ     = 2'd0,
        RATE_067HZ   = 2'd1,
        RATE_SLOW    = 2'd2,
        RATE_1HZ_ALT = 2'd3
    } rate_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/tick_select.sv
// Tick source selection: rising-edge detector on the slow square wave and
// a mux producing a single-cycle tick_sel pulse from the chosen source.
module tick_select
    import tick_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  tick_1hz,
    input  logic  tick_067hz,
    input  logic  slow_lvl,
    input  rate_e rate_sel,
    output logic  tick_sel
);

    logic slow_prev_p0;
    logic slow_tick_p1;

    // p0: history of slow_lvl; p1: registered rising-edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slow_prev_p0 <= 1'b0;
            slow_tick_p1 <= 1'b0;
        end else begin
            slow_prev_p0 <= slow_lvl;
            slow_tick_p1 <= slow_lvl & ~slow_prev_p0;
        end
    end

    always_comb begin
        case (rate_sel)
            RATE_067HZ: tick_sel = tick_067hz;
            RATE_SLOW:  tick_sel = slow_tick_p1;
            default:    tick_sel = tick_1hz;
        endcase
    end

endmodule

// File: rtl/tick_sequencer.sv
// Step sequencer advancing one step per selected tick, with pause, abort
// and a one-cycle done pulse; all outputs are registered.
module tick_sequencer
    import tick_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1hz,
    input  logic              tick_067hz,
    input  logic              slow_lvl,
    input  logic [1:0]        rate_sel,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    input  logic [STEP_W-1:0] num_steps,
    output logic [STEP_W-1:0] step_idx,
    output logic              step_strobe,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    rate_e             rate_q, rate_d;
    logic [STEP_W-1:0] num_q, num_d;
    logic [STEP_W-1:0] step_d;
    logic              strobe_d, busy_d, done_d;
    logic              tick_sel;

    // Saturating increment keeps step_idx from wrapping on any path
    function automatic logic [STEP_W-1:0] step_inc(input logic [STEP_W-1:0] v);
        if (&v) return v;
        return v + {{(STEP_W-1){1'b0}}, 1'b1};
    endfunction

    tick_select u_tick_select (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .tick_067hz (tick_067hz),
        .slow_lvl   (slow_lvl),
        .rate_sel   (rate_q),
        .tick_sel   (tick_sel)
    );

    always_comb begin
        state_d  = state_q;
        rate_d   = rate_q;
        num_d    = num_q;
        step_d   = step_idx;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rate_d  = rate_e'(rate_sel);
                    num_d   = num_steps;
                    step_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // abort outranks everything; pause drops a coincident tick
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (num_q == '0) begin
                    state_d = ST_DONE;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if (tick_sel) begin
                    step_d   = step_inc(step_idx);
                    strobe_d = 1'b1;
                    if (step_d == num_q) state_d = ST_DONE;
                end
            end
            ST_PAUSED: begin
                if (abort)       state_d = ST_IDLE;
                else if (!pause) state_d = ST_RUN;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    end

    // p0: state, latched configuration and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rate_q      <= RATE_1HZ;
            num_q       <= '0;
            step_idx    <= '0;
            step_strobe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            num_q       <= num_d;
            step_idx    <= step_d;
            step_strobe <= strobe_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer: normal run, slow-edge source, pause,
// abort, zero-length sequence and mid-sequence reset.
module tb_tick_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_067hz = 1'b0;
    logic       slow_lvl = 1'b0;
    logic [1:0] rate_sel = 2'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] num_steps = 4'd0;
    logic [3:0] step_idx;
    logic       step_strobe;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    tick_sequencer #(.STEP_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1hz    (tick_1hz),
        .tick_067hz  (tick_067hz),
        .slow_lvl    (slow_lvl),
        .rate_sel    (rate_sel),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .num_steps   (num_steps),
        .step_idx    (step_idx),
        .step_strobe (step_strobe),
        .busy        (busy),
        .done        (done)
    );

    always #10 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int s, input int st, input int b, input int d);
        chk({tag, ".step_idx"}, int'(step_idx), s);
        chk({tag, ".strobe"}, int'(step_strobe), st);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".done"}, int'(done), d);
    endtask

    initial begin
        // reset state
        cyc(); cyc();
        chk_all("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc();
        chk_all("post_reset_idle", 0, 0, 0, 0);

        // 1 Hz source, 3 steps; config changes after start must be ignored
        rate_sel = 2'd0; num_steps = 4'd3; start = 1'b1;
        cyc();
        start = 1'b0; rate_sel = 2'd2; num_steps = 4'd7;
        chk_all("run_start", 0, 0, 1, 0);
        tick_067hz = 1'b1;
        cyc();
        tick_067hz = 1'b0;
        chk("unselected_tick.strobe", int'(step_strobe), 0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            tick_1hz = 1'b1;
            cyc();
            tick_1hz = 1'b0;
            chk("run1hz.strobe", int'(step_strobe), 1);
            chk("run1hz.step_idx", int'(step_idx), k);
            chk("run1hz.done_early", int'(done), 0);
        end
        chk("run1hz.busy_after_last", int'(busy), 0);
        cyc();
        chk_all("run1hz.done_pulse", 3, 0, 0, 1);
        cyc();
        chk_all("run1hz.idle_hold", 3, 0, 0, 0);

        // slow_lvl source: strobes on rising edges only
        rate_sel = 2'd2; num_steps = 4'd2; start = 1'b1;
        cyc();
        start = 1'b0;
        slow_lvl = 1'b1;
        cyc();
        chk("slow.edge_latency", int'(step_strobe), 0);
        cyc();
        chk("slow.rise1.strobe", int'(step_strobe), 1);
        chk("slow.rise1.step_idx", int'(step_idx), 1);
        cyc();
        chk("slow.high_hold.strobe", int'(step_strobe), 0);
        slow_lvl = 1'b0;
        cyc(); cyc();
        chk("slow.fall.strobe", int'(step_strobe), 0);
        chk("slow.fall.step_idx", int'(step_idx), 1);
        slow_lvl = 1'b1;
        cyc(); cyc();
        chk_all("slow.rise2", 2, 1, 0, 0);
        cyc();
        chk_all("slow.done", 2, 0, 0, 1);
        slow_lvl = 1'b0;
        cyc();

        // pause drops ticks, then sequence resumes to 5
        rate_sel = 2'd0; num_steps = 4'd5; start = 1'b1;
        cyc();
        start = 1'b0;
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        chk("pause.step1", int'(step_idx), 1);
        pause = 1'b1; tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        chk_all("pause.tick_a", 1, 0, 1, 0);
        cyc();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        chk_all("pause.tick_b", 1, 0, 1, 0);
        pause = 1'b0;
        cyc();
        for (int k = 2; k <= 5; k++) begin
            tick_1hz = 1'b1;
            cyc();
            chk("pause.resume.step_idx", int'(step_idx), k);
            chk("pause.resume.strobe", int'(step_strobe), 1);
            tick_1hz = 1'b0;
        end
        cyc();
        chk_all("pause.done", 5, 0, 0, 1);
        cyc();

        // abort in the same cycle as a tick at step 2; tick with start not counted
        num_steps = 4'd4; start = 1'b1; tick_1hz = 1'b1;
        cyc();
        start = 1'b0;
        chk_all("start_tick", 0, 0, 1, 0);
        cyc();
        cyc();
        tick_1hz = 1'b0;
        chk("abort.pre_step", int'(step_idx), 2);
        tick_1hz = 1'b1; abort = 1'b1;
        cyc();
        tick_1hz = 1'b0; abort = 1'b0;
        chk_all("abort.edge", 2, 0, 0, 0);
        cyc();
        chk_all("abort.after", 2, 0, 0, 0);
        abort = 1'b1; tick_1hz = 1'b1;
        cyc();
        abort = 1'b0; tick_1hz = 1'b0;
        chk_all("abort.idle_ignored", 2, 0, 0, 0);

        // zero-length sequence and start while busy ignored
        num_steps = 4'd0; start = 1'b1;
        cyc();
        num_steps = 4'd5;
        chk_all("zero.run", 0, 0, 1, 0);
        cyc();
        start = 1'b0;
        chk_all("zero.to_done", 0, 0, 0, 0);
        cyc();
        chk_all("zero.done", 0, 0, 0, 1);
        cyc();
        chk_all("zero.idle", 0, 0, 0, 0);

        // asynchronous reset mid-sequence
        num_steps = 4'd4; start = 1'b1;
        cyc();
        start = 1'b0;
        tick_1hz = 1'b1;
        cyc(); cyc();
        tick_1hz = 1'b0;
        chk("rst.pre_step", int'(step_idx), 2);
        #2 rst_n = 1'b0;
        #1 chk_all("rst.async", 0, 0, 0, 0);
        tick_1hz = 1'b1;
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        tick_1hz = 1'b0;
        chk_all("rst.no_strobe", 0, 0, 0, 0);
        num_steps = 4'd1; start = 1'b1;
        cyc();
        start = 1'b0; tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        chk_all("rst.restart", 1, 1, 0, 0);
        cyc();
        chk("rst.restart.done", int'(done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
